// File: rtl/sram_arbiter_if.sv
// Purpose: bundle of the requester-side and sram-side signals of the two-port sram arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold p*_req and payload until p*_gnt; ready=0 blocks all grants.
// Ports: ready; p0_*/p1_* req, we, addr, wdata, gnt, rvalid, rdata; mem_cs, mem_we,
//   mem_addr, mem_wdata, mem_rdata. The slave modport is the arbiter; the master modport is
//   the environment (requesters plus the sram macro driving mem_rdata).
interface sram_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16
);
  localparam int NB = DATAWIDTH / 8;

  logic                 ready;

  logic                 p0_req;
  logic [NB-1:0]        p0_we;
  logic [ADDRWIDTH-1:0] p0_addr;
  logic [DATAWIDTH-1:0] p0_wdata;
  logic                 p0_gnt;
  logic                 p0_rvalid;
  logic [DATAWIDTH-1:0] p0_rdata;

  logic                 p1_req;
  logic [NB-1:0]        p1_we;
  logic [ADDRWIDTH-1:0] p1_addr;
  logic [DATAWIDTH-1:0] p1_wdata;
  logic                 p1_gnt;
  logic                 p1_rvalid;
  logic [DATAWIDTH-1:0] p1_rdata;

  logic                 mem_cs;
  logic [NB-1:0]        mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic [DATAWIDTH-1:0] mem_rdata;

  modport slave (
    output ready,
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    input  ready,
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port sram between two requesters.
// Latency: grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: a losing or not-ready requester holds req and payload until it is granted.
// Ports: clk; rst (synchronous, active-high); bus (sram_arbiter_if.slave) with ready,
//   per-port req/we/addr/wdata in and gnt/rvalid/rdata out, and the sram cs/we/addr/wdata/rdata pins.
// Build option: SRAM_ARB_CLEAR_EN adds an INIT state that zero-fills MEMDEPTH words after reset.
module sram_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16,
  parameter int MEMDEPTH  = 1 << ADDRWIDTH
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  if (MEMDEPTH < 1 || MEMDEPTH > (1 << ADDRWIDTH)) begin : g_bad_memdepth
    $error("sram_arbiter: MEMDEPTH must be in 1..2**ADDRWIDTH");
  end

  logic                 run;       // accepting requests this cycle
  logic                 clearing;  // zero-fill sweep drives the sram this cycle
  logic [ADDRWIDTH-1:0] clr_addr;

`ifdef SRAM_ARB_CLEAR_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDRWIDTH-1:0] CLR_LAST = ADDRWIDTH'(MEMDEPTH - 1);

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
    end else if (state == ST_INIT) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == CLR_LAST) state <= ST_RUN;
    end
  end

  // Gating with rst keeps every output at its reset value while rst is held.
  assign run      = (state == ST_RUN)  && !rst;
  assign clearing = (state == ST_INIT) && !rst;
`else
  assign run      = !rst;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // last_grant = 1 means port 1 was served most recently, so port 0 wins the next conflict.
  logic last_grant;
  logic gnt0, gnt1;
  logic rd0, rd1;

  assign gnt0 = run && bus.p0_req && (!bus.p1_req ||  last_grant);
  assign gnt1 = run && bus.p1_req && (!bus.p0_req || !last_grant);
  assign rd0  = gnt0 && (bus.p0_we == '0);
  assign rd1  = gnt1 && (bus.p1_we == '0);

  assign bus.ready  = run;
  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  // Any grant counts, so a port that ran alone yields the next conflict to the other.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= 1'b1;
    else if (gnt0) last_grant <= 1'b0;
    else if (gnt1) last_grant <= 1'b1;
  end

  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (clearing) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = '1;
      bus.mem_addr  = clr_addr;
    end else if (gnt0) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = bus.p0_we;
      bus.mem_addr  = bus.p0_addr;
      bus.mem_wdata = bus.p0_wdata;
    end else if (gnt1) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = bus.p1_we;
      bus.mem_addr  = bus.p1_addr;
      bus.mem_wdata = bus.p1_wdata;
    end
  end

  // The sram read data is combinational, so it is captured at the granting edge.
  logic                 rvalid0_q, rvalid1_q;
  logic [DATAWIDTH-1:0] rdata0_q,  rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0) rdata0_q <= bus.mem_rdata;
      if (rd1) rdata1_q <= bus.mem_rdata;
    end
  end

  // A pulse already registered when rst arrives must not escape.
  assign bus.p0_rvalid = rvalid0_q && !rst;
  assign bus.p1_rvalid = rvalid1_q && !rst;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

endmodule
